// File: rtl/nios_oci_dct_packer_pkg.sv
// nios_oci_dct_pkg: shared sizes, types and slot helper for the DCT packer.
// NIOS_OCI_DCT_OVF_EN selects lossy mode in the top.
package nios_oci_dct_pkg;

  localparam int SYM_W = 2;
  localparam int SYMS  = 15;
  localparam int BUF_W = SYM_W * SYMS;
  localparam int CNT_W = 4;
  localparam int OVF_W = 8;

  typedef logic [SYM_W-1:0] dct_sym_t;
  typedef logic [BUF_W-1:0] dct_frame_t;
  typedef logic [CNT_W-1:0] dct_cnt_t;

  localparam dct_cnt_t DCT_FULL = dct_cnt_t'(SYMS);

  // Write symbol s into slot idx, LSB-first packing.
  function automatic dct_frame_t dct_put(
    input dct_frame_t f,
    input dct_cnt_t   idx,
    input dct_sym_t   s
  );
    dct_frame_t r;
    r = f;
    for (int i = 0; i < SYMS; i++) begin
      if (idx == dct_cnt_t'(i)) begin
        r[i*SYM_W +: SYM_W] = s;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_oci_dct_packer_if.sv
// Trace symbol input, live accumulator view and frame output of the packer.
// slave = packer side, master = encoder/trace-store side.
interface nios_oci_dct_packer_if;
  import nios_oci_dct_pkg::*;

  logic       sym_valid;
  dct_sym_t   sym_data;
  logic       sym_ready;
  logic       flush;
  dct_frame_t dct_buffer;
  dct_cnt_t   dct_count;
  logic       frm_valid;
  dct_frame_t frm_data;
  dct_cnt_t   frm_count;
  logic       frm_ready;
  logic [OVF_W-1:0] ovf_count;

  modport slave (
    input  sym_valid, sym_data, flush, frm_ready,
    output sym_ready, dct_buffer, dct_count,
    output frm_valid, frm_data, frm_count, ovf_count
  );

  modport master (
    output sym_valid, sym_data, flush, frm_ready,
    input  sym_ready, dct_buffer, dct_count,
    input  frm_valid, frm_data, frm_count, ovf_count
  );

endinterface

// File: rtl/nios_oci_dct_packer_outreg.sv
// One-entry valid/ready holding register for completed DCT frames.
// Payload only changes on load, so it stays stable while stalled.
module nios_oci_dct_outreg
  import nios_oci_dct_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  dct_frame_t data_i,
  input  dct_cnt_t   count_i,
  input  logic       ready_i,
  output logic       valid_o,
  output dct_frame_t data_o,
  output dct_cnt_t   count_o
);

  logic       valid_q, valid_d;
  dct_frame_t data_q, data_d;
  dct_cnt_t   count_q, count_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      count_d = count_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/nios_oci_dct_packer.sv
// DCT packer: 2-bit trace symbols into 30-bit frames with flush.
// Define NIOS_OCI_DCT_OVF_EN for lossy mode (drop + ovf_count).
module nios_oci_dct_packer
  import nios_oci_dct_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  nios_oci_dct_packer_if.slave bus
);

  dct_frame_t acc_q, acc_d;
  dct_cnt_t   cnt_q, cnt_d;
  logic       pend_q, pend_d;

  logic full;
  logic out_free;
  logic xfer;
  logic can_take;
  logic take;
  logic frm_valid;

  assign full     = (cnt_q == DCT_FULL);
  assign out_free = !frm_valid | bus.frm_ready;
  assign xfer     = out_free & (full | (pend_q & (cnt_q != '0)));
  assign can_take = !pend_q & (!full | out_free);
  assign take     = bus.sym_valid & can_take;

  // A symbol taken in a transfer cycle lands in slot 0.
  always_comb begin
    acc_d = xfer ? '0 : acc_q;
    cnt_d = xfer ? '0 : cnt_q;
    if (take) begin
      acc_d = dct_put(acc_d, cnt_d, bus.sym_data);
      cnt_d = cnt_d + dct_cnt_t'(1);
    end
    pend_d = pend_q ? !xfer : (bus.flush & (cnt_d != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  nios_oci_dct_outreg u_outreg (
    .clk     (clk),
    .rst_n   (reset_n),
    .load_i  (xfer),
    .data_i  (acc_q),
    .count_i (cnt_q),
    .ready_i (bus.frm_ready),
    .valid_o (frm_valid),
    .data_o  (bus.frm_data),
    .count_o (bus.frm_count)
  );

  assign bus.frm_valid  = frm_valid;
  assign bus.dct_buffer = acc_q;
  assign bus.dct_count  = cnt_q;

`ifdef NIOS_OCI_DCT_OVF_EN
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             drop;

  assign drop = bus.sym_valid & !can_take;

  always_comb begin
    ovf_d = ovf_q;
    if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.sym_ready = 1'b1;
  assign bus.ovf_count = ovf_q;
`else
  assign bus.sym_ready = can_take;
  assign bus.ovf_count = '0;
`endif

endmodule

// File: tb/tb_nios_oci_dct_packer.sv
// Bench for nios_oci_dct_packer: directed scenarios plus random traffic
// against a queue-based frame model.
module tb_nios_oci_dct_packer;
  import nios_oci_dct_pkg::*;

  logic clk;
  logic reset_n;

  nios_oci_dct_packer_if bus ();

  nios_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;

  int acc[$];
  bit hv;
  int hdata;
  int hcnt;
  bit pend;
  int ovf;
  int handed;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pack();
    int r;
    r = 0;
    foreach (acc[i]) r += acc[i] << (2 * i);
    return r;
  endfunction

  task automatic model_reset();
    acc   = {};
    hv    = 1'b0;
    hdata = 0;
    hcnt  = 0;
    pend  = 1'b0;
    ovf   = 0;
  endtask

  task automatic check_state();
    chk("dct_count", 32'(bus.dct_count), 32'(acc.size()));
    chk("dct_buffer", 32'(bus.dct_buffer), 32'(pack()));
    chk("frm_valid", 32'(bus.frm_valid), 32'(hv));
    if (hv) begin
      chk("frm_data", 32'(bus.frm_data), 32'(hdata));
      chk("frm_count", 32'(bus.frm_count), 32'(hcnt));
    end
    chk("ovf_count", 32'(bus.ovf_count), 32'(ovf));
  endtask

  // One clock: drive at negedge, check ready, step model, check state.
  task automatic cycle(input bit v, input logic [1:0] d,
                       input bit fl, input bit fr);
    bit can;
    bit xfer;
    int nacc[$];
    bus.sym_valid = v;
    bus.sym_data  = d;
    bus.flush     = fl;
    bus.frm_ready = fr;
    #1;
    can = !pend && (acc.size() < SYMS || !hv || fr);
`ifdef NIOS_OCI_DCT_OVF_EN
    chk("sym_ready", 32'(bus.sym_ready), 32'd1);
`else
    chk("sym_ready", 32'(bus.sym_ready), 32'(can));
`endif
    xfer = (!hv || fr) && (acc.size() == SYMS || (pend && acc.size() > 0));
    if (hv && fr) handed++;
    nacc = acc;
    if (xfer) begin
      hdata = pack();
      hcnt  = acc.size();
      hv    = 1'b1;
      nacc  = {};
    end else if (fr) begin
      hv = 1'b0;
    end
    if (v && can) begin
      nacc.push_back(int'(d));
    end
`ifdef NIOS_OCI_DCT_OVF_EN
    else if (v && ovf < 255) begin
      ovf++;
    end
`endif
    if (pend) pend = !xfer;
    else      pend = fl && nacc.size() > 0;
    acc = nacc;
    @(negedge clk);
    check_state();
  endtask

  initial begin
    int h0;
    n_run  = 0;
    n_fail = 0;
    handed = 0;
    model_reset();
    reset_n       = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_data  = '0;
    bus.flush     = 1'b0;
    bus.frm_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_sym_ready", 32'(bus.sym_ready), 32'd1);
    chk("rst_frm_data", 32'(bus.frm_data), 32'd0);
    chk("rst_frm_count", 32'(bus.frm_count), 32'd0);
    check_state();
    reset_n = 1'b1;
    repeat (2) cycle(1'b0, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) cycle(1'b1, 2'(i % 4), 1'b0, 1'b1);
    chk("t2_full_count", 32'(bus.dct_count), 32'd15);
    cycle(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t2_frm_valid", 32'(bus.frm_valid), 32'd1);
    chk("t2_frm_data", 32'(bus.frm_data), 32'h24E4E4E4);
    chk("t2_frm_count", 32'(bus.frm_count), 32'd15);
    chk("t2_dct_count", 32'(bus.dct_count), 32'd0);

    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd3, 1'b0, 1'b1);
    cycle(1'b0, 2'd0, 1'b1, 1'b1);
    cycle(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t3_frm_valid", 32'(bus.frm_valid), 32'd1);
    chk("t3_frm_data", 32'(bus.frm_data), 32'h3F);
    chk("t3_frm_count", 32'(bus.frm_count), 32'd3);
    cycle(1'b0, 2'd0, 1'b1, 1'b1);
    cycle(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t3_no_frame", 32'(bus.frm_valid), 32'd0);

    for (int i = 0; i < 30; i++) cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
    chk("t4_dct_count", 32'(bus.dct_count), 32'd15);
`ifndef NIOS_OCI_DCT_OVF_EN
    chk("t4_sym_ready", 32'(bus.sym_ready), 32'd0);
`endif
    h0 = handed;
    repeat (3) cycle(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t4_frames", 32'(handed - h0), 32'd2);

    for (int i = 0; i < 22; i++) cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
    chk("t5_pre_count", 32'(bus.dct_count), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_dct_count", 32'(bus.dct_count), 32'd0);
    chk("t5_frm_valid", 32'(bus.frm_valid), 32'd0);
    chk("t5_frm_data", 32'(bus.frm_data), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 2'd0, 1'b0, 1'b0);

`ifdef NIOS_OCI_DCT_OVF_EN
    for (int i = 0; i < 40; i++) cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
    chk("t6_ovf_count", 32'(bus.ovf_count), 32'd10);
    repeat (3) cycle(1'b0, 2'd0, 1'b0, 1'b1);
`endif

    repeat (1500) begin
      cycle($urandom_range(0, 9) < 7, 2'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
